// File: rtl/mailbox_pkg.sv
// Shared definitions for the dual-direction mailbox: register offsets,
// STATUS bit positions and a helper that assembles the STATUS byte.
// Optional feature macro: MAILBOX_IRQ_EN (adds irq_a / irq_b outputs).
package mailbox_pkg;

  localparam logic [7:0] REG_DATA   = 8'h00;
  localparam logic [7:0] REG_STATUS = 8'h01;

  localparam int ST_RX_NE   = 0;
  localparam int ST_TX_FULL = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_UDF     = 3;
  localparam int ST_MASK    = 7;

  function automatic logic [7:0] pack_status(input logic rx_ne, input logic tx_full,
                                             input logic ovf, input logic udf,
                                             input logic mask);
    logic [7:0] s;
    s              = 8'h00;
    s[ST_RX_NE]    = rx_ne;
    s[ST_TX_FULL]  = tx_full;
    s[ST_OVF]      = ovf;
    s[ST_UDF]      = udf;
    s[ST_MASK]     = mask;
    return s;
  endfunction

endpackage

// File: rtl/mailbox_fifo_core.sv
// Synchronous byte FIFO for one mailbox direction. Pushes to a full FIFO
// and pops from an empty one are ignored here; the caller flags them.
// The popped byte appears on dout_o the cycle after pop_i, else 8'h00.
module mailbox_fifo_core #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [7:0]    din_i,
  input  logic          pop_i,
  output logic [7:0]    dout_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [7:0]    dout_q;
  logic          push_ok;
  logic          pop_ok;

  // Fullness/emptiness come from the count at the start of the cycle.
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign count_o = count_q;
  assign dout_o  = dout_q;

  // Storage write; the array itself carries no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= din_i;
  end

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Registered read port: popped byte for one cycle, zero otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) dout_q <= 8'h00;
    else       dout_q <= pop_ok ? mem[rd_ptr_q] : 8'h00;
  end

endmodule

// File: rtl/mailbox_fifo.sv
// Two-sided mailbox: FIFO AB (A pushes, B pops) and FIFO BA (B pushes,
// A pops), each side with a DATA and a STATUS register at its own base.
// Optional feature macro: MAILBOX_IRQ_EN adds registered irq_a / irq_b
// and a writable per-side mask (STATUS bit7).
module mailbox_fifo
  import mailbox_pkg::*;
#(
  parameter logic [7:0] DEVADDR_A = 8'h28,
  parameter logic [7:0] DEVADDR_B = 8'h28,
  parameter int         DEPTH     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] OUTBUS_ADDR_A,
  input  logic [7:0] OUTBUS_DATA_A,
  input  logic       OUTBUS_WE_A,
  input  logic [7:0] OUTBUS_ADDR_B,
  input  logic [7:0] OUTBUS_DATA_B,
  input  logic       OUTBUS_WE_B,
  input  logic [7:0] INBUS_ADDR_A,
  output logic [7:0] INBUS_DATA_A,
  input  logic       INBUS_RE_A,
  input  logic [7:0] INBUS_ADDR_B,
  output logic [7:0] INBUS_DATA_B,
  input  logic       INBUS_RE_B
`ifdef MAILBOX_IRQ_EN
  ,
  output logic       irq_a,
  output logic       irq_b
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  // Side 0 is A, side 1 is B; FIFO n is the one side n pushes into.
  logic [7:0]    out_addr   [2];
  logic [7:0]    out_data   [2];
  logic [7:0]    in_addr    [2];
  logic [7:0]    in_data    [2];
  logic [7:0]    fifo_dout  [2];
  logic [CW-1:0] fifo_count [2];
  logic [1:0]    out_we;
  logic [1:0]    in_re;
  logic [1:0]    rd_data_hit;
  logic [1:0]    fifo_full;
  logic [1:0]    fifo_empty;

  assign out_addr[0] = OUTBUS_ADDR_A;
  assign out_addr[1] = OUTBUS_ADDR_B;
  assign out_data[0] = OUTBUS_DATA_A;
  assign out_data[1] = OUTBUS_DATA_B;
  assign out_we      = {OUTBUS_WE_B, OUTBUS_WE_A};
  assign in_addr[0]  = INBUS_ADDR_A;
  assign in_addr[1]  = INBUS_ADDR_B;
  assign in_re       = {INBUS_RE_B, INBUS_RE_A};
  assign INBUS_DATA_A = in_data[0];
  assign INBUS_DATA_B = in_data[1];

`ifdef MAILBOX_IRQ_EN
  logic [1:0] irq;
  assign irq_a = irq[0];
  assign irq_b = irq[1];
`endif

  for (genvar gi = 0; gi < 2; gi++) begin : gen_side
    localparam logic [7:0] BASE = (gi == 0) ? DEVADDR_A : DEVADDR_B;
    localparam int         RX   = 1 - gi;

    logic       wr_data_hit;
    logic       wr_stat_hit;
    logic       rd_stat_hit;
    logic       ovf_q;
    logic       udf_q;
    logic       mask;
    logic [7:0] stat_rd_q;
    logic [7:0] status;

    assign wr_data_hit     = out_we[gi] && (out_addr[gi] == BASE + REG_DATA);
    assign wr_stat_hit     = out_we[gi] && (out_addr[gi] == BASE + REG_STATUS);
    assign rd_data_hit[gi] = in_re[gi]  && (in_addr[gi]  == BASE + REG_DATA);
    assign rd_stat_hit     = in_re[gi]  && (in_addr[gi]  == BASE + REG_STATUS);

    assign status = pack_status(fifo_count[RX] != '0, fifo_full[gi], ovf_q, udf_q, mask);

    mailbox_fifo_core #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (wr_data_hit),
      .din_i   (out_data[gi]),
      .pop_i   (rd_data_hit[RX]),
      .dout_o  (fifo_dout[gi]),
      .count_o (fifo_count[gi]),
      .full_o  (fifo_full[gi]),
      .empty_o (fifo_empty[gi])
    );

    // Sticky error flags: a new event wins over a same-cycle W1C clear.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        ovf_q <= 1'b0;
        udf_q <= 1'b0;
      end else begin
        if (wr_data_hit && fifo_full[gi])                ovf_q <= 1'b1;
        else if (wr_stat_hit && out_data[gi][ST_OVF])    ovf_q <= 1'b0;
        if (rd_data_hit[gi] && fifo_empty[RX])           udf_q <= 1'b1;
        else if (wr_stat_hit && out_data[gi][ST_UDF])    udf_q <= 1'b0;
      end
    end

    // STATUS read path: snapshot of the current state, one-cycle latency.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) stat_rd_q <= 8'h00;
      else       stat_rd_q <= rd_stat_hit ? status : 8'h00;
    end

    // Both read sources are zero when idle, so they OR onto the bus.
    assign in_data[gi] = fifo_dout[RX] | stat_rd_q;

`ifdef MAILBOX_IRQ_EN
    logic mask_q;
    logic irq_q;
    assign mask    = mask_q;
    assign irq[gi] = irq_q;

    // Interrupt mask, loaded from bit7 of any STATUS write.
    always_ff @(posedge clk or posedge reset) begin
      if (reset)            mask_q <= 1'b0;
      else if (wr_stat_hit) mask_q <= out_data[gi][ST_MASK];
    end

    // Registered interrupt: data waiting for this side and unmasked.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) irq_q <= 1'b0;
      else       irq_q <= (fifo_count[RX] != '0) && mask_q;
    end
`else
    assign mask = 1'b0;
`endif
  end

endmodule

// File: tb/tb_mailbox_fifo.sv
// Self-checking bench for mailbox_fifo (DEPTH=4, side B at a different
// base address). Table-driven vectors feed a per-side scoreboard of
// expected INBUS bytes; reset and interrupt timing use short sequences.
module tb_mailbox_fifo;
  import mailbox_pkg::*;

  localparam int         DEPTH = 4;
  localparam logic [7:0] DA = 8'h28;
  localparam logic [7:0] SA = 8'h29;
  localparam logic [7:0] DB = 8'h40;
  localparam logic [7:0] SB = 8'h41;
`ifdef MAILBOX_IRQ_EN
  localparam logic [7:0] MASK_RB = 8'h80;
`else
  localparam logic [7:0] MASK_RB = 8'h00;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] OUTBUS_ADDR_A, OUTBUS_DATA_A, OUTBUS_ADDR_B, OUTBUS_DATA_B;
  logic       OUTBUS_WE_A, OUTBUS_WE_B;
  logic [7:0] INBUS_ADDR_A, INBUS_ADDR_B;
  logic [7:0] INBUS_DATA_A, INBUS_DATA_B;
  logic       INBUS_RE_A, INBUS_RE_B;
`ifdef MAILBOX_IRQ_EN
  logic       irq_a, irq_b;
`endif

  mailbox_fifo #(.DEVADDR_A(DA), .DEVADDR_B(DB), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .OUTBUS_ADDR_A (OUTBUS_ADDR_A),
    .OUTBUS_DATA_A (OUTBUS_DATA_A),
    .OUTBUS_WE_A   (OUTBUS_WE_A),
    .OUTBUS_ADDR_B (OUTBUS_ADDR_B),
    .OUTBUS_DATA_B (OUTBUS_DATA_B),
    .OUTBUS_WE_B   (OUTBUS_WE_B),
    .INBUS_ADDR_A  (INBUS_ADDR_A),
    .INBUS_DATA_A  (INBUS_DATA_A),
    .INBUS_RE_A    (INBUS_RE_A),
    .INBUS_ADDR_B  (INBUS_ADDR_B),
    .INBUS_DATA_B  (INBUS_DATA_B),
    .INBUS_RE_B    (INBUS_RE_B)
`ifdef MAILBOX_IRQ_EN
    ,
    .irq_a         (irq_a),
    .irq_b         (irq_b)
`endif
  );

  always #5 clk = ~clk;

  typedef enum logic [1:0] {NOP, WR, RD} op_e;
  typedef struct {
    string      name;
    op_e        a_op;
    logic [7:0] a_addr;
    logic [7:0] a_data;
    op_e        b_op;
    logic [7:0] b_addr;
    logic [7:0] b_data;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_q_a[$];
  logic [7:0] exp_q_b[$];
  string      name_q[$];
  int         errors = 0;
  int         checks = 0;

  function automatic vec_t mk(input string n, input op_e ao, input logic [7:0] aa,
                              input logic [7:0] ad, input op_e bo, input logic [7:0] ba,
                              input logic [7:0] bd, input logic [7:0] ea,
                              input logic [7:0] eb);
    vec_t v;
    v.name = n; v.a_op = ao; v.a_addr = aa; v.a_data = ad;
    v.b_op = bo; v.b_addr = ba; v.b_data = bd; v.exp_a = ea; v.exp_b = eb;
    return v;
  endfunction

  task automatic check(input string n, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", n, act, exp);
    end else begin
      $display("ok   %s: %h", n, act);
    end
  endtask

  // Drive one cycle of bus activity and queue the expected read bytes.
  task automatic drive(input vec_t v);
    OUTBUS_WE_A   = (v.a_op == WR);
    OUTBUS_ADDR_A = v.a_addr;
    OUTBUS_DATA_A = v.a_data;
    INBUS_RE_A    = (v.a_op == RD);
    INBUS_ADDR_A  = v.a_addr;
    OUTBUS_WE_B   = (v.b_op == WR);
    OUTBUS_ADDR_B = v.b_addr;
    OUTBUS_DATA_B = v.b_data;
    INBUS_RE_B    = (v.b_op == RD);
    INBUS_ADDR_B  = v.b_addr;
    exp_q_a.push_back(v.exp_a);
    exp_q_b.push_back(v.exp_b);
    name_q.push_back(v.name);
  endtask

  // Drive at a falling edge, compare at the next falling edge.
  task automatic run(input vec_t v);
    string n;
    drive(v);
    @(negedge clk);
    n = name_q.pop_front();
    check({n, "/A"}, INBUS_DATA_A, exp_q_a.pop_front());
    check({n, "/B"}, INBUS_DATA_B, exp_q_b.pop_front());
  endtask

  task automatic idle();
    OUTBUS_WE_A = 1'b0; INBUS_RE_A = 1'b0;
    OUTBUS_WE_B = 1'b0; INBUS_RE_B = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    OUTBUS_ADDR_A = 8'h00; OUTBUS_DATA_A = 8'h00;
    OUTBUS_ADDR_B = 8'h00; OUTBUS_DATA_B = 8'h00;
    INBUS_ADDR_A  = 8'h00; INBUS_ADDR_B  = 8'h00;
    idle();
    repeat (2) @(negedge clk);
    check("reset/A", INBUS_DATA_A, 8'h00);
    check("reset/B", INBUS_DATA_B, 8'h00);
    reset = 1'b0;

    // basic AB transfer
    vecs.push_back(mk("a_wr_11",     WR, DA, 8'h11, NOP, 8'h00, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk("a_wr_22",     WR, DA, 8'h22, NOP, 8'h00, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk("b_rd_11",     NOP, 8'h00, 8'h00, RD, DB, 8'h00, 8'h00, 8'h11));
    vecs.push_back(mk("b_rd_22",     NOP, 8'h00, 8'h00, RD, DB, 8'h00, 8'h00, 8'h22));
    vecs.push_back(mk("b_stat_idle", NOP, 8'h00, 8'h00, RD, SB, 8'h00, 8'h00, 8'h00));
    // overflow with DEPTH=4
    for (int i = 1; i <= 5; i++)
      vecs.push_back(mk($sformatf("a_wr_%02h", i), WR, DA, 8'(i), NOP, 8'h00, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk("stat_ovf",    RD, SA, 8'h00, RD, SB, 8'h00, 8'h06, 8'h01));
    for (int i = 1; i <= 4; i++)
      vecs.push_back(mk($sformatf("b_drain_%02h", i), NOP, 8'h00, 8'h00, RD, DB, 8'h00, 8'h00, 8'(i)));
    vecs.push_back(mk("b_rd_empty",  NOP, 8'h00, 8'h00, RD, DB, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk("b_stat_udf",  WR, SA, 8'h04, RD, SB, 8'h00, 8'h00, 8'h08));
    vecs.push_back(mk("a_stat_clr",  RD, SA, 8'h00, WR, SB, 8'h08, 8'h00, 8'h00));
    vecs.push_back(mk("b_stat_clr",  NOP, 8'h00, 8'h00, RD, SB, 8'h00, 8'h00, 8'h00));
    // underflow on side A
    vecs.push_back(mk("a_rd_empty",  RD, DA, 8'h00, NOP, 8'h00, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk("a_stat_udf",  RD, SA, 8'h00, NOP, 8'h00, 8'h00, 8'h08, 8'h00));
    vecs.push_back(mk("a_w1c_udf",   WR, SA, 8'h08, NOP, 8'h00, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk("a_stat_clr2", RD, SA, 8'h00, NOP, 8'h00, 8'h00, 8'h00, 8'h00));
    // undecoded addresses ignored
    vecs.push_back(mk("a_wr_bad",    WR, 8'h2A, 8'h55, RD, 8'h42, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk("a_wr_b_addr", WR, DB, 8'h66, RD, SB, 8'h00, 8'h00, 8'h00));
    // simultaneous push and pop
    vecs.push_back(mk("a_wr_a1",     WR, DA, 8'hA1, NOP, 8'h00, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk("a_wr_a2",     WR, DA, 8'hA2, NOP, 8'h00, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk("push_pop",    WR, DA, 8'h33, RD, DB, 8'h00, 8'h00, 8'hA1));
    vecs.push_back(mk("stat_cnt2",   RD, SA, 8'h00, RD, SB, 8'h00, 8'h00, 8'h01));
    vecs.push_back(mk("b_rd_a2",     NOP, 8'h00, 8'h00, RD, DB, 8'h00, 8'h00, 8'hA2));
    vecs.push_back(mk("b_rd_33",     NOP, 8'h00, 8'h00, RD, DB, 8'h00, 8'h00, 8'h33));
    vecs.push_back(mk("b_stat_mt",   NOP, 8'h00, 8'h00, RD, SB, 8'h00, 8'h00, 8'h00));
    // push to full FIFO dropped even with a same-cycle pop
    for (int i = 1; i <= 4; i++)
      vecs.push_back(mk($sformatf("a_fill_c%0d", i), WR, DA, 8'(8'hC0 + i), NOP, 8'h00, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk("full_push_pop", WR, DA, 8'hC5, RD, DB, 8'h00, 8'h00, 8'hC1));
    vecs.push_back(mk("a_stat_ovf3", RD, SA, 8'h00, RD, DB, 8'h00, 8'h04, 8'hC2));
    vecs.push_back(mk("b_rd_c3",     NOP, 8'h00, 8'h00, RD, DB, 8'h00, 8'h00, 8'hC3));
    vecs.push_back(mk("b_rd_c4",     NOP, 8'h00, 8'h00, RD, DB, 8'h00, 8'h00, 8'hC4));
    vecs.push_back(mk("b_rd_no_c5",  NOP, 8'h00, 8'h00, RD, DB, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk("clr_both",    WR, SA, 8'h04, WR, SB, 8'h08, 8'h00, 8'h00));
    vecs.push_back(mk("stat_both0",  RD, SA, 8'h00, RD, SB, 8'h00, 8'h00, 8'h00));
    // BA direction
    vecs.push_back(mk("b_wr_77",     NOP, 8'h00, 8'h00, WR, DB, 8'h77, 8'h00, 8'h00));
    vecs.push_back(mk("a_stat_rxne", RD, SA, 8'h00, RD, SB, 8'h00, 8'h01, 8'h00));
    vecs.push_back(mk("a_rd_77",     RD, DA, 8'h00, NOP, 8'h00, 8'h00, 8'h77, 8'h00));
    // mask bit
    vecs.push_back(mk("a_wr_mask",   WR, SA, 8'h80, NOP, 8'h00, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk("a_stat_mask", RD, SA, 8'h00, NOP, 8'h00, 8'h00, MASK_RB, 8'h00));
    vecs.push_back(mk("a_unmask",    WR, SA, 8'h00, NOP, 8'h00, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk("a_stat_nomsk", RD, SA, 8'h00, NOP, 8'h00, 8'h00, 8'h00, 8'h00));
    // queue three bytes ahead of the reset sequence
    vecs.push_back(mk("pre_rst_e1",  WR, DA, 8'hE1, NOP, 8'h00, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk("pre_rst_e2",  WR, DA, 8'hE2, NOP, 8'h00, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk("pre_rst_e3",  WR, DA, 8'hE3, WR, DB, 8'h99, 8'h00, 8'h00));

    @(negedge clk);
    foreach (vecs[i]) run(vecs[i]);

    // Reset with bytes queued and a read in flight.
    idle();
    INBUS_RE_B = 1'b1; INBUS_ADDR_B = DB;
    @(posedge clk);
    #2;
    check("inflight_b", INBUS_DATA_B, 8'hE1);
    INBUS_RE_B = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_async/A", INBUS_DATA_A, 8'h00);
    check("rst_async/B", INBUS_DATA_B, 8'h00);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    run(mk("post_rst_stat", RD, SA, 8'h00, RD, SB, 8'h00, 8'h00, 8'h00));
    run(mk("post_rst_data", RD, DA, 8'h00, RD, DB, 8'h00, 8'h00, 8'h00));
    run(mk("post_rst_stat2", RD, SA, 8'h00, RD, SB, 8'h00, 8'h08, 8'h08));

`ifdef MAILBOX_IRQ_EN
    run(mk("b_mask_on",  NOP, 8'h00, 8'h00, WR, SB, 8'h80, 8'h00, 8'h00));
    run(mk("a_wr_5a",    WR, DA, 8'h5A, NOP, 8'h00, 8'h00, 8'h00, 8'h00));
    run(mk("irq_wait",   NOP, 8'h00, 8'h00, NOP, 8'h00, 8'h00, 8'h00, 8'h00));
    check("irq_b_set", {7'b0, irq_b}, 8'h01);
    check("irq_a_quiet", {7'b0, irq_a}, 8'h00);
    run(mk("b_rd_5a",    NOP, 8'h00, 8'h00, RD, DB, 8'h00, 8'h00, 8'h5A));
    check("irq_b_pop_cycle", {7'b0, irq_b}, 8'h01);
    run(mk("irq_drop",   NOP, 8'h00, 8'h00, NOP, 8'h00, 8'h00, 8'h00, 8'h00));
    check("irq_b_clear", {7'b0, irq_b}, 8'h00);
`endif

    idle();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mailbox_fifo.md
MAILBOX_FIFO -- requirements
Module: mailbox_fifo

Interface
REQ-001 SHALL have parameter DEVADDR_A, default 8'h28: base bus address on side A.
REQ-002 SHALL have parameter DEVADDR_B, default 8'h28: base bus address on side B.
REQ-003 SHALL have parameter DEPTH, default 16: entries per direction; power of 2, range 2..128.
REQ-004 SHALL have port clk, input, 1: the single clock for all logic.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have ports OUTBUS_ADDR_A/_B, input, 8: write address per side.
REQ-007 SHALL have ports OUTBUS_DATA_A/_B, input, 8: write data per side.
REQ-008 SHALL have ports OUTBUS_WE_A/_B, input, 1: write strobe per side.
REQ-009 SHALL have ports INBUS_ADDR_A/_B, input, 8: read address per side.
REQ-010 SHALL have ports INBUS_DATA_A/_B, output, 8: read data per side, OR-combined onto the bus.
REQ-011 SHALL have ports INBUS_RE_A/_B, input, 1: read strobe per side.

Function
REQ-012 SHALL contain FIFO AB (A pushes, B pops) and FIFO BA (B pushes, A pops), each DEPTH x 8.
REQ-013 SHALL decode per side: DEVADDR+0 = DATA, DEVADDR+1 = STATUS; the two sides decode independently.
REQ-014 SHALL push OUTBUS_DATA_x into the side's TX FIFO when OUTBUS_WE_x is high and OUTBUS_ADDR_x == DEVADDR_x+0.
REQ-015 SHALL pop the side's RX FIFO in the cycle INBUS_RE_x is high and INBUS_ADDR_x == DEVADDR_x+0, and present the popped byte on INBUS_DATA_x in the following cycle.
REQ-016 SHALL drive INBUS_DATA_x to 8'h00 in every cycle not following a matching read.
REQ-017 SHALL define STATUS as: bit0 RX not empty, bit1 TX full, bit2 sticky TX overflow, bit3 sticky RX underflow, bits6:4 reserved 0, bit7 IRQ mask; one-cycle read latency, no side effects on read.
REQ-018 SHALL drop a push to a full FIFO, leave the contents unchanged and set that side's overflow flag; fullness is judged on the count at the start of the cycle, even if a pop occurs in the same cycle.
REQ-019 SHALL return 8'h00 for a pop from an empty FIFO, leave the pointers unchanged and set that side's underflow flag.
REQ-020 SHALL perform a simultaneous push and pop on a non-empty, non-full FIFO in the same cycle, leaving the count unchanged.
REQ-021 SHALL clear the sticky flags on a write to STATUS with bit2 or bit3 set (write-1-to-clear).
REQ-022 SHALL load bit7 of a STATUS write into the mask.
REQ-023 SHALL wrap the read and write pointers modulo DEPTH.
REQ-024 SHALL distinguish full from empty with a log2(DEPTH)+1-bit count.
REQ-025 SHALL ignore writes and reads at any address other than the two decoded addresses.

Reset
REQ-026 SHALL, while reset is high, asynchronously clear both FIFO pointers and counts, all sticky flags, the masks and both INBUS_DATA outputs to 0.
REQ-027 SHALL, on reset mid-operation, discard any in-flight read data and all queued bytes.
REQ-028 SHALL NOT require the FIFO storage array to be reset.

Configuration
REQ-029 SHALL, with MAILBOX_IRQ_EN defined, add outputs irq_a and irq_b (1 bit each), registered, where irq_x = RX not empty AND mask_x; both reset to 0.
REQ-030 SHALL, without MAILBOX_IRQ_EN, omit irq_a and irq_b, read STATUS bit7 as 0 and ignore mask writes.

Structure
REQ-031 SHALL place register offsets (DATA=0, STATUS=1) and the STATUS bit positions in shared package mailbox_pkg.
REQ-032 SHALL implement each direction as sub-module mailbox_fifo_core (sync FIFO with push, pop, dout, count, full, empty), instantiated twice.

Verification
REQ-033 SHALL test: A writes 8'h11, 8'h22 to DEVADDR_A; B reads DEVADDR_B twice -> 8'h11 then 8'h22; B STATUS then reads 8'h00.
REQ-034 SHALL test: with DEPTH=4, A writes 5 bytes (8'h01..8'h05) -> A STATUS reads 8'h06; B drains 8'h01..8'h04.
REQ-035 SHALL test: A reads DATA with FIFO BA empty -> 8'h00 and STATUS bit3 set; A writes STATUS 8'h08 -> bit3 cleared.
REQ-036 SHALL test: with FIFO AB holding 2 entries, A pushes 8'h33 and B pops in the same cycle -> count stays 2; FIFO order is preserved.
REQ-037 SHALL test: reset pulsed with 3 bytes queued -> both STATUS registers read 8'h00 and INBUS_DATA_A/_B are 0.
REQ-038 SHALL test, with MAILBOX_IRQ_EN: B writes STATUS 8'h80, then A pushes a byte -> irq_b high by the following cycle; after B pops the last byte, irq_b drops the cycle after the pop.
